command_issue_arbiter: RTL and testbench

Shares the single PSL command port between the AFU's command requesters: WED fetch, compute-unit read, compute-unit write and restart. Each cycle it picks one requester round-robin, gives the command a free PSL tag, and spends one command credit. It takes tags and credits back from PSL responses. It sits between the per-requester command buffers and the command-out register stage of the AFU control path.

---
 rtl/command_issue_arbiter_pkg.sv | 26 ++
 rtl/command_issue_arbiter_round_robin_arbiter.sv | 31 +++
 rtl/command_issue_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_command_issue_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/command_issue_arbiter_pkg.sv
// Shared AFU control-path types: command buffer line, arbiter state, requester slots.
package command_issue_arbiter_pkg;

  typedef struct packed {
    logic [12:0] command;
    logic [2:0]  abt;
    logic [7:0]  tag;
    logic [11:0] size;
    logic [63:0] address;
  } CommandBufferLine;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } arbiter_state_t;

  localparam int WED_REQ     = 0;
  localparam int READ_REQ    = 1;
  localparam int WRITE_REQ   = 2;
  localparam int RESTART_REQ = 3;

  localparam int TAG_FIELD_W       = 8;
  localparam int RESPONSE_CREDIT_W = 9;

endpackage

// File: rtl/command_issue_arbiter_round_robin_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module round_robin_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  request,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic found;
  int   idx;

  // Scan N slots starting at ptr; the first pending one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!found && request[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/command_issue_arbiter.sv
// Arbitrates the PSL command port among AFU requesters, allocating tags and
// spending credits; reclaims both from PSL responses.
module command_issue_arbiter
  import command_issue_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int NUM_TAGS       = 32,
  parameter int MAX_CREDITS    = 64
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enabled_in,
  input  logic                            room_valid,
  input  logic [7:0]                      room,
  input  logic [NUM_REQUESTERS-1:0]       request_in,
  input  CommandBufferLine                command_in [NUM_REQUESTERS],
  output logic [NUM_REQUESTERS-1:0]       grant_out,
  output CommandBufferLine                command_out,
  output logic                            command_valid_out,
  input  logic                            response_valid,
  input  logic [7:0]                      response_tag,
  input  logic signed [8:0]               response_credits,
  output logic [$clog2(NUM_TAGS):0]       outstanding_out,
  output logic [$clog2(MAX_CREDITS):0]    credits_out,
  output logic                            drained_out,
  output logic                            tag_error_out
);

  localparam int RW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam int TW = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  localparam int OW = $clog2(NUM_TAGS) + 1;
  localparam int CW = $clog2(MAX_CREDITS) + 1;
  // Wide enough for credits + a full-range signed response without overflow.
  localparam int SW = ((CW > RESPONSE_CREDIT_W) ? CW : RESPONSE_CREDIT_W) + 2;
  localparam logic signed [SW-1:0] MAX_S = SW'(MAX_CREDITS);

  arbiter_state_t          state_q, state_d;
  logic [RW-1:0]           ptr_q, ptr_d;
  logic [NUM_TAGS-1:0]     tag_map_q, tag_map_d;
  logic [CW-1:0]           credits_q, credits_d;
  logic [OW-1:0]           outstanding_q, outstanding_d;
  logic                    tag_error_q;

  logic                    run_ok;
  logic [NUM_REQUESTERS-1:0] rr_grant;
  logic [RW-1:0]           rr_idx;
  logic [TW:0]             free_sel;
  logic                    tag_avail;
  logic [TW-1:0]           free_tag;
  logic                    issue_p0;
  logic                    resp_in_range;
  logic [TW-1:0]           rtag_idx;
  logic                    release_p0;
  logic                    tag_err_p0;
  logic signed [SW-1:0]    credit_rsp_p0;
  logic signed [SW-1:0]    credit_sum_p0;
  CommandBufferLine        cmd_p0;
  CommandBufferLine        cmd_p1;
  logic                    vld_p1;

  function automatic logic [TW:0] lowest_free(input logic [NUM_TAGS-1:0] map);
    lowest_free = '0;
    for (int t = NUM_TAGS - 1; t >= 0; t--) begin
      if (!map[t]) lowest_free = {1'b1, TW'(t)};
    end
  endfunction

  function automatic logic [CW-1:0] sat_credits(input logic signed [SW-1:0] v);
    if (v[SW-1])        sat_credits = '0;
    else if (v > MAX_S) sat_credits = CW'(MAX_CREDITS);
    else                sat_credits = CW'(v);
  endfunction

  function automatic logic [CW-1:0] sat_room(input logic [7:0] r);
    if (int'(r) > MAX_CREDITS) sat_room = CW'(MAX_CREDITS);
    else                       sat_room = CW'(r);
  endfunction

  round_robin_arbiter #(
    .N  (NUM_REQUESTERS),
    .IW (RW)
  ) u_rr (
    .request   (request_in),
    .ptr       (ptr_q),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: start on croom, drain when the job stops, idle once empty.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (room_valid) state_d = RUN;
      RUN:     if (!enabled_in) state_d = DRAIN;
      DRAIN: begin
        if (enabled_in)               state_d = RUN;
        else if (outstanding_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: grant permission and drained indication.
  always_comb begin
    run_ok      = (state_q == RUN) && enabled_in;
    drained_out = (state_q == IDLE) || ((state_q == DRAIN) && (outstanding_q == '0));
  end

  // p0: issue decision, tag pick, release and credit arithmetic.
  always_comb begin
    free_sel      = lowest_free(tag_map_q);
    tag_avail     = free_sel[TW];
    free_tag      = free_sel[TW-1:0];
    issue_p0      = run_ok && (credits_q != '0) && tag_avail && (|request_in);
    grant_out     = issue_p0 ? rr_grant : '0;

    resp_in_range = int'(response_tag) < NUM_TAGS;
    rtag_idx      = response_tag[TW-1:0];
    release_p0    = response_valid && resp_in_range && tag_map_q[rtag_idx];
    tag_err_p0    = response_valid && !release_p0;

    tag_map_d = tag_map_q;
    if (issue_p0)   tag_map_d[free_tag] = 1'b1;
    if (release_p0) tag_map_d[rtag_idx] = 1'b0;

    outstanding_d = outstanding_q + OW'(issue_p0) - OW'(release_p0);

    credit_rsp_p0 = response_valid
                  ? {{(SW-RESPONSE_CREDIT_W){response_credits[8]}}, response_credits}
                  : '0;
    credit_sum_p0 = $signed(SW'(credits_q)) - $signed(SW'(issue_p0)) + credit_rsp_p0;
    if ((state_q == IDLE) && room_valid) credits_d = sat_room(room);
    else                                 credits_d = sat_credits(credit_sum_p0);

    ptr_d = ptr_q;
    if (issue_p0) ptr_d = (rr_idx == RW'(NUM_REQUESTERS - 1)) ? '0 : rr_idx + 1'b1;

    cmd_p0     = command_in[rr_idx];
    cmd_p0.tag = TAG_FIELD_W'(free_tag);
  end

  // Tag bitmap, credit and outstanding counters, pointer, sticky error.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q         <= '0;
      tag_map_q     <= '0;
      credits_q     <= '0;
      outstanding_q <= '0;
      tag_error_q   <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      tag_map_q     <= tag_map_d;
      credits_q     <= credits_d;
      outstanding_q <= outstanding_d;
      tag_error_q   <= tag_error_q | tag_err_p0;
    end
  end

  // p1: registered command-out stage, tag field already replaced.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      cmd_p1 <= '0;
    end else begin
      vld_p1 <= issue_p0;
      if (issue_p0) cmd_p1 <= cmd_p0;
    end
  end

  assign command_out       = cmd_p1;
  assign command_valid_out = vld_p1;
  assign outstanding_out   = outstanding_q;
  assign credits_out       = credits_q;
  assign tag_error_out     = tag_error_q;

endmodule

// File: tb/tb_command_issue_arbiter.sv
// Scenario bench for command_issue_arbiter with a command-out scoreboard.
module tb_command_issue_arbiter;
  import command_issue_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int NT = 32;
  localparam int MC = 64;

  logic                clock = 1'b0;
  logic                reset;
  logic                enabled_in;
  logic                room_valid;
  logic [7:0]          room;
  logic [NR-1:0]       request_in;
  CommandBufferLine    command_in [NR];
  logic [NR-1:0]       grant_out;
  CommandBufferLine    command_out;
  logic                command_valid_out;
  logic                response_valid;
  logic [7:0]          response_tag;
  logic signed [8:0]   response_credits;
  logic [5:0]          outstanding_out;
  logic [6:0]          credits_out;
  logic                drained_out;
  logic                tag_error_out;

  int vectors     = 0;
  int miscompares = 0;
  CommandBufferLine exp_q[$];

  always #5 clock = ~clock;

  command_issue_arbiter #(
    .NUM_REQUESTERS (NR),
    .NUM_TAGS       (NT),
    .MAX_CREDITS    (MC)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .enabled_in        (enabled_in),
    .room_valid        (room_valid),
    .room              (room),
    .request_in        (request_in),
    .command_in        (command_in),
    .grant_out         (grant_out),
    .command_out       (command_out),
    .command_valid_out (command_valid_out),
    .response_valid    (response_valid),
    .response_tag      (response_tag),
    .response_credits  (response_credits),
    .outstanding_out   (outstanding_out),
    .credits_out       (credits_out),
    .drained_out       (drained_out),
    .tag_error_out     (tag_error_out)
  );

  function automatic CommandBufferLine make_cmd(input int req, input int tag);
    CommandBufferLine c;
    c.command = 13'h0A00 + 13'(req);
    c.abt     = 3'(req);
    c.tag     = 8'(tag);
    c.size    = 12'd128;
    c.address = 64'h0000_0001_0000_0000 + 64'(req) * 64'h80;
    return c;
  endfunction

  // One clock; pop the scoreboard whenever a command comes out.
  task automatic advance();
    CommandBufferLine e;
    @(negedge clock);
    if (command_valid_out === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected_command got=%h required=none", command_out);
      end else begin
        e = exp_q.pop_front();
        if (command_out !== e) begin
          miscompares++;
          $display("FAIL sb_command got=%h required=%h", command_out, e);
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; enabled_in = 1'b0; room_valid = 1'b0; room = '0; request_in = '0;
    response_valid = 1'b0; response_tag = '0; response_credits = '0;
    advance();
    advance();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    enabled_in = 1'b1; request_in = 4'hF;
    #1;
    vectors++; if (grant_out !== 4'b0) begin miscompares++; $display("FAIL reset_grant got=%b required=0000", grant_out); end
    vectors++; if (command_valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_cvalid got=%b required=0", command_valid_out); end
    vectors++; if (command_out !== '0) begin miscompares++; $display("FAIL reset_cmd got=%h required=0", command_out); end
    vectors++; if (outstanding_out !== 6'd0) begin miscompares++; $display("FAIL reset_outstanding got=%0d required=0", outstanding_out); end
    vectors++; if (credits_out !== 7'd0) begin miscompares++; $display("FAIL reset_credits got=%0d required=0", credits_out); end
    vectors++; if (drained_out !== 1'b1) begin miscompares++; $display("FAIL reset_drained got=%b required=1", drained_out); end
    vectors++; if (tag_error_out !== 1'b0) begin miscompares++; $display("FAIL reset_tagerr got=%b required=0", tag_error_out); end
  endtask

  task automatic test_fill4();
    do_reset();
    enabled_in = 1'b1; request_in = 4'hF; room = 8'd4; room_valid = 1'b1;
    advance();
    room_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++; if (grant_out !== 4'(1 << k)) begin miscompares++; $display("FAIL fill4_grant%0d got=%b required=%b", k, grant_out, 4'(1 << k)); end
      exp_q.push_back(make_cmd(k, k));
      advance();
    end
    #1;
    vectors++; if (grant_out !== 4'b0) begin miscompares++; $display("FAIL fill4_blocked got=%b required=0000", grant_out); end
    vectors++; if (credits_out !== 7'd0) begin miscompares++; $display("FAIL fill4_credits got=%0d required=0", credits_out); end
    vectors++; if (outstanding_out !== 6'd4) begin miscompares++; $display("FAIL fill4_outstanding got=%0d required=4", outstanding_out); end
    vectors++; if (drained_out !== 1'b0) begin miscompares++; $display("FAIL fill4_drained got=%b required=0", drained_out); end
  endtask

  task automatic test_reuse();
    response_valid = 1'b1; response_tag = 8'd2; response_credits = 9'sd1;
    #1;
    vectors++; if (grant_out !== 4'b0) begin miscompares++; $display("FAIL reuse_same_cycle got=%b required=0000", grant_out); end
    advance();
    response_valid = 1'b0;
    #1;
    vectors++; if (credits_out !== 7'd1) begin miscompares++; $display("FAIL reuse_credit got=%0d required=1", credits_out); end
    vectors++; if (outstanding_out !== 6'd3) begin miscompares++; $display("FAIL reuse_release got=%0d required=3", outstanding_out); end
    vectors++; if (grant_out !== 4'b0001) begin miscompares++; $display("FAIL reuse_grant got=%b required=0001", grant_out); end
    exp_q.push_back(make_cmd(0, 2));
    advance();
    #1;
    vectors++; if (credits_out !== 7'd0) begin miscompares++; $display("FAIL reuse_credits_after got=%0d required=0", credits_out); end
    vectors++; if (outstanding_out !== 6'd4) begin miscompares++; $display("FAIL reuse_outstanding got=%0d required=4", outstanding_out); end
    vectors++; if (grant_out !== 4'b0) begin miscompares++; $display("FAIL reuse_blocked got=%b required=0000", grant_out); end
  endtask

  task automatic test_tag_error();
    request_in = '0;
    response_valid = 1'b1; response_tag = 8'd5; response_credits = 9'sd3;
    advance();
    vectors++; if (tag_error_out !== 1'b1) begin miscompares++; $display("FAIL tagerr_set got=%b required=1", tag_error_out); end
    vectors++; if (outstanding_out !== 6'd4) begin miscompares++; $display("FAIL tagerr_outstanding got=%0d required=4", outstanding_out); end
    vectors++; if (credits_out !== 7'd3) begin miscompares++; $display("FAIL tagerr_credits got=%0d required=3", credits_out); end
    response_tag = 8'd40; response_credits = -9'sd1;
    advance();
    vectors++; if (credits_out !== 7'd2) begin miscompares++; $display("FAIL tagerr_range_credits got=%0d required=2", credits_out); end
    vectors++; if (outstanding_out !== 6'd4) begin miscompares++; $display("FAIL tagerr_range_outstanding got=%0d required=4", outstanding_out); end
    response_tag = 8'd0; response_credits = -9'sd100;
    advance();
    vectors++; if (credits_out !== 7'd0) begin miscompares++; $display("FAIL clamp_low got=%0d required=0", credits_out); end
    vectors++; if (outstanding_out !== 6'd3) begin miscompares++; $display("FAIL release_tag0 got=%0d required=3", outstanding_out); end
    response_tag = 8'd0; response_credits = 9'sd255;
    advance();
    response_valid = 1'b0;
    vectors++; if (credits_out !== 7'd64) begin miscompares++; $display("FAIL clamp_high got=%0d required=64", credits_out); end
    vectors++; if (outstanding_out !== 6'd3) begin miscompares++; $display("FAIL double_release got=%0d required=3", outstanding_out); end
    advance();
    vectors++; if (tag_error_out !== 1'b1) begin miscompares++; $display("FAIL tagerr_sticky got=%b required=1", tag_error_out); end
  endtask

  task automatic test_fill32();
    do_reset();
    enabled_in = 1'b1; request_in = 4'hF; room = 8'd200; room_valid = 1'b1;
    advance();
    room_valid = 1'b0;
    #1;
    vectors++; if (credits_out !== 7'd64) begin miscompares++; $display("FAIL room_saturate got=%0d required=64", credits_out); end
    for (int k = 0; k < NT; k++) begin
      #1;
      vectors++; if (grant_out !== 4'(1 << (k % 4))) begin miscompares++; $display("FAIL fill32_grant%0d got=%b required=%b", k, grant_out, 4'(1 << (k % 4))); end
      exp_q.push_back(make_cmd(k % 4, k));
      advance();
    end
    #1;
    vectors++; if (grant_out !== 4'b0) begin miscompares++; $display("FAIL fill32_blocked got=%b required=0000", grant_out); end
    vectors++; if (credits_out !== 7'd32) begin miscompares++; $display("FAIL fill32_credits got=%0d required=32", credits_out); end
    vectors++; if (outstanding_out !== 6'd32) begin miscompares++; $display("FAIL fill32_outstanding got=%0d required=32", outstanding_out); end
  endtask

  task automatic test_back_to_back();
    response_valid = 1'b1; response_tag = 8'd7; response_credits = 9'sd1;
    advance();
    response_tag = 8'd8;
    #1;
    vectors++; if (credits_out !== 7'd33) begin miscompares++; $display("FAIL b2b_credits1 got=%0d required=33", credits_out); end
    vectors++; if (outstanding_out !== 6'd31) begin miscompares++; $display("FAIL b2b_outstanding1 got=%0d required=31", outstanding_out); end
    vectors++; if (grant_out !== 4'b0001) begin miscompares++; $display("FAIL b2b_grant1 got=%b required=0001", grant_out); end
    exp_q.push_back(make_cmd(0, 7));
    advance();
    response_valid = 1'b0;
    #1;
    vectors++; if (credits_out !== 7'd33) begin miscompares++; $display("FAIL b2b_netzero got=%0d required=33", credits_out); end
    vectors++; if (outstanding_out !== 6'd31) begin miscompares++; $display("FAIL b2b_outstanding2 got=%0d required=31", outstanding_out); end
    vectors++; if (grant_out !== 4'b0010) begin miscompares++; $display("FAIL b2b_grant2 got=%b required=0010", grant_out); end
    exp_q.push_back(make_cmd(1, 8));
    advance();
    #1;
    vectors++; if (credits_out !== 7'd32) begin miscompares++; $display("FAIL b2b_credits3 got=%0d required=32", credits_out); end
    vectors++; if (grant_out !== 4'b0) begin miscompares++; $display("FAIL b2b_full got=%b required=0000", grant_out); end
  endtask

  task automatic test_reset_mid();
    request_in = '0;
    reset = 1'b1;
    advance();
    reset = 1'b0;
    vectors++; if (outstanding_out !== 6'd0) begin miscompares++; $display("FAIL midrst_outstanding got=%0d required=0", outstanding_out); end
    vectors++; if (credits_out !== 7'd0) begin miscompares++; $display("FAIL midrst_credits got=%0d required=0", credits_out); end
    vectors++; if (command_valid_out !== 1'b0) begin miscompares++; $display("FAIL midrst_cvalid got=%b required=0", command_valid_out); end
    vectors++; if (drained_out !== 1'b1) begin miscompares++; $display("FAIL midrst_drained got=%b required=1", drained_out); end
    response_valid = 1'b1; response_tag = 8'd3; response_credits = 9'sd0;
    advance();
    response_valid = 1'b0;
    vectors++; if (tag_error_out !== 1'b1) begin miscompares++; $display("FAIL midrst_stale_resp got=%b required=1", tag_error_out); end
    vectors++; if (outstanding_out !== 6'd0) begin miscompares++; $display("FAIL midrst_stale_outstanding got=%0d required=0", outstanding_out); end
  endtask

  task automatic test_drain();
    do_reset();
    enabled_in = 1'b1; request_in = 4'hF; room = 8'd8; room_valid = 1'b1;
    advance();
    room_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++; if (grant_out !== 4'(1 << k)) begin miscompares++; $display("FAIL drain_grant%0d got=%b required=%b", k, grant_out, 4'(1 << k)); end
      exp_q.push_back(make_cmd(k, k));
      advance();
    end
    enabled_in = 1'b0;
    #1;
    vectors++; if (grant_out !== 4'b0) begin miscompares++; $display("FAIL drain_disable_grant got=%b required=0000", grant_out); end
    advance();
    #1;
    vectors++; if (grant_out !== 4'b0) begin miscompares++; $display("FAIL drain_grant got=%b required=0000", grant_out); end
    vectors++; if (drained_out !== 1'b0) begin miscompares++; $display("FAIL drain_busy got=%b required=0", drained_out); end
    vectors++; if (outstanding_out !== 6'd3) begin miscompares++; $display("FAIL drain_outstanding got=%0d required=3", outstanding_out); end
    for (int t = 0; t < 3; t++) begin
      response_valid = 1'b1; response_tag = 8'(t); response_credits = 9'sd1;
      advance();
      vectors++; if (drained_out !== (t == 2)) begin miscompares++; $display("FAIL drain_resp%0d got=%b required=%b", t, drained_out, (t == 2)); end
    end
    response_valid = 1'b0;
    advance();
    enabled_in = 1'b1;
    #1;
    vectors++; if (drained_out !== 1'b1) begin miscompares++; $display("FAIL drain_idle_drained got=%b required=1", drained_out); end
    vectors++; if (credits_out !== 7'd8) begin miscompares++; $display("FAIL drain_credits got=%0d required=8", credits_out); end
    advance();
    #1;
    vectors++; if (grant_out !== 4'b0) begin miscompares++; $display("FAIL idle_no_grant got=%b required=0000", grant_out); end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) command_in[i] = make_cmd(i, 255);
    test_reset();
    test_fill4();
    test_reuse();
    test_tag_error();
    test_fill32();
    test_back_to_back();
    test_reset_mid();
    test_drain();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_missing_commands got=%0d pending required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
